ps2_key_receiver: RTL

PS/2 device-to-host receiver that samples the keyboard's ps2_clk/ps2_data lines and deframes 11-bit frames into scan-code bytes. It tracks make/break (F0) and extended (E0) prefixes and presents the currently held key's make code on data[7:0]. data[7:0] feeds datadecoder directly, so a release yields 0 and silences the tone. It sits between the board PS/2 pins and datadecoder.

---
 rtl/ps2_key_receiver.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronizes and glitch-filters the pins, deframes 11-bit frames,
// and tracks make/break/extended prefixes to present the currently held key code.
module ps2_key_receiver #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic [7:0] scancode,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_filt_clk;
  logic [FW-1:0] r_filt_cnt;
  logic          r_fall, r_fall_dat;

  state_t        r_state;
  logic [3:0]    r_bitcnt;
  logic [8:0]    r_shift;
  logic [TW-1:0] r_tocnt;
  logic          r_brk, r_ext;
  logic [7:0]    r_data, r_scancode;
  logic          r_code_valid, r_frame_err;

  // Payload plus parity must hold an odd number of ones, and the stop bit must be high.
  function automatic logic frame_ok(input logic [8:0] bits, input logic stop);
    return (^bits) & stop;
  endfunction

  // Input stage: synchronizers, glitch filter, falling-edge pulse with its data sample
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_filt_clk <= 1'b1;
      r_filt_cnt <= '0;
      r_fall     <= 1'b0;
      r_fall_dat <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
      r_fall     <= 1'b0;
      r_fall_dat <= r_dat_s2;
      if (r_clk_s2 == r_filt_clk) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_filt_clk <= r_clk_s2;
        r_filt_cnt <= '0;
        r_fall     <= r_filt_clk;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  // Frame stage: deframing, timeout, key tracking and registered pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_bitcnt     <= '0;
      r_tocnt      <= '0;
      r_brk        <= 1'b0;
      r_ext        <= 1'b0;
      r_data       <= '0;
      r_scancode   <= '0;
      r_code_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_code_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tocnt  <= '0;
          r_bitcnt <= '0;
          if (r_fall) begin
            if (!r_fall_dat) r_state <= SHIFT;
            else             r_frame_err <= 1'b1;
          end
        end
        SHIFT: begin
          if (r_fall) begin
            r_tocnt <= '0;
            if (r_bitcnt == 4'd9) begin
              r_state  <= IDLE;
              r_bitcnt <= '0;
              if (frame_ok(r_shift, r_fall_dat)) begin
                r_code_valid <= 1'b1;
                r_scancode   <= r_shift[7:0];
                if (r_shift[7:0] == 8'hF0) begin
                  r_brk <= 1'b1;
                end else if (r_shift[7:0] == 8'hE0) begin
                  r_ext <= 1'b1;
                end else if (r_ext) begin
                  r_ext <= 1'b0;
                  r_brk <= 1'b0;
                end else if (r_brk) begin
                  if (r_shift[7:0] == r_data) r_data <= '0;
                  r_brk <= 1'b0;
                end else begin
                  r_data <= r_shift[7:0];
                end
              end else begin
                r_frame_err <= 1'b1;
              end
            end else begin
              r_shift  <= {r_fall_dat, r_shift[8:1]};
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end else if (r_tocnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_frame_err <= 1'b1;
            r_state     <= IDLE;
            r_bitcnt    <= '0;
            r_tocnt     <= '0;
          end else begin
            r_tocnt <= r_tocnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data       = r_data;
  assign scancode   = r_scancode;
  assign code_valid = r_code_valid;
  assign frame_err  = r_frame_err;

endmodule
